// File: rtl/npc_pkg.sv
// Shared types and defaults for the npc core memory arbiter: FSM encoding,
// requester identities and the error-response defaults.
package npc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_RESP  = 2'd2,
      ST_FLUSH = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWNER_IFU = 1'b0,
      OWNER_LSU = 1'b1
   } owner_t;

   localparam int unsigned TIMEOUT_DEFAULT   = 255;
   localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;

   // Round-robin pick between two requesters: a lone requester wins,
   // otherwise the one that did not own the last granted transaction.
   function automatic owner_t rr_pick(input logic ifu, input logic lsu, input owner_t last);
      if (ifu && lsu)
         return (last == OWNER_IFU) ? OWNER_LSU : OWNER_IFU;
      else if (lsu)
         return OWNER_LSU;
      else
         return OWNER_IFU;
   endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// Saturating 8-bit response timer for the arbiter: counts enabled cycles after
// a clear and flags when the count reaches LIMIT.
module mem_arb_timeout #(
   parameter logic [7:0] LIMIT = 8'd255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [7:0] count_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_reg <= 8'd0;
      end else if (clear) begin
         count_reg <= 8'd0;
      end else if (enable && (count_reg != LIMIT)) begin
         count_reg <= count_reg + 8'd1;
      end
   end

   assign expired = (count_reg == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU and LSU, with one
// outstanding transaction and a response-timeout guard.
module mem_arbiter
   import npc_pkg::*;
#(
   parameter int unsigned TIMEOUT   = TIMEOUT_DEFAULT,
   parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ifu_req,
   input  logic [31:0] ifu_addr,
   output logic        ifu_ready,
   output logic        ifu_rvalid,
   output logic [31:0] ifu_rdata,
   output logic        ifu_err,
   input  logic        lsu_req,
   input  logic        lsu_wen,
   input  logic [31:0] lsu_addr,
   input  logic [31:0] lsu_wdata,
   input  logic [3:0]  lsu_wstrb,
   output logic        lsu_ready,
   output logic        lsu_rvalid,
   output logic [31:0] lsu_rdata,
   output logic        lsu_err,
   output logic        mem_req,
   output logic        mem_wen,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   arb_state_t  state_reg, state_next;
   owner_t      owner_reg, last_owner_reg, pick;
   logic        pay_wen_reg;
   logic [31:0] pay_addr_reg;
   logic [31:0] pay_wdata_reg;
   logic [3:0]  pay_wstrb_reg;

   logic accept;
   logic resp_timeout;
   logic timer_en;
   logic timer_clear;
   logic timer_expired;

   assign pick = rr_pick(ifu_req, lsu_req, last_owner_reg);

   always_comb begin
      state_next   = state_reg;
      accept       = 1'b0;
      resp_timeout = 1'b0;
      timer_en     = 1'b0;
      ifu_ready    = 1'b0;
      ifu_rvalid   = 1'b0;
      ifu_rdata    = 32'd0;
      ifu_err      = 1'b0;
      lsu_ready    = 1'b0;
      lsu_rvalid   = 1'b0;
      lsu_rdata    = 32'd0;
      lsu_err      = 1'b0;
      mem_req      = 1'b0;
      mem_wen      = 1'b0;
      mem_addr     = 32'd0;
      mem_wdata    = 32'd0;
      mem_wstrb    = 4'd0;

      case (state_reg)
         ST_IDLE: begin
            // Ready is gated by reset so every output reads 0 while held in reset.
            if (rst && (ifu_req || lsu_req)) begin
               accept     = 1'b1;
               ifu_ready  = (pick == OWNER_IFU);
               lsu_ready  = (pick == OWNER_LSU);
               state_next = ST_REQ;
            end
         end
         ST_REQ: begin
            mem_req   = 1'b1;
            mem_wen   = pay_wen_reg;
            mem_addr  = pay_addr_reg;
            mem_wdata = pay_wdata_reg;
            mem_wstrb = pay_wen_reg ? pay_wstrb_reg : 4'd0;
            if (mem_gnt) begin
               state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            if (mem_rvalid) begin
               if (owner_reg == OWNER_IFU) begin
                  ifu_rvalid = 1'b1;
                  ifu_rdata  = mem_rdata;
               end else begin
                  lsu_rvalid = 1'b1;
                  lsu_rdata  = mem_rdata;
               end
               state_next = ST_IDLE;
            end else if (timer_expired) begin
               resp_timeout = 1'b1;
               if (owner_reg == OWNER_IFU) begin
                  ifu_rvalid = 1'b1;
                  ifu_rdata  = ERR_RDATA;
                  ifu_err    = 1'b1;
               end else begin
                  lsu_rvalid = 1'b1;
                  lsu_rdata  = ERR_RDATA;
                  lsu_err    = 1'b1;
               end
               state_next = ST_FLUSH;
            end else begin
               timer_en = 1'b1;
            end
         end
         ST_FLUSH: begin
            // The stale response is swallowed here, never forwarded.
            if (mem_rvalid || timer_expired) begin
               state_next = ST_IDLE;
            end else begin
               timer_en = 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign timer_clear = (state_reg == ST_IDLE) || (state_reg == ST_REQ) || resp_timeout;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= ST_IDLE;
         owner_reg      <= OWNER_IFU;
         last_owner_reg <= OWNER_IFU;
         pay_wen_reg    <= 1'b0;
         pay_addr_reg   <= 32'd0;
         pay_wdata_reg  <= 32'd0;
         pay_wstrb_reg  <= 4'd0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            owner_reg <= pick;
            if (pick == OWNER_LSU) begin
               pay_wen_reg   <= lsu_wen;
               pay_addr_reg  <= lsu_addr;
               pay_wdata_reg <= lsu_wdata;
               pay_wstrb_reg <= lsu_wstrb;
            end else begin
               pay_wen_reg   <= 1'b0;
               pay_addr_reg  <= ifu_addr;
               pay_wdata_reg <= 32'd0;
               pay_wstrb_reg <= 4'd0;
            end
         end
         // Round-robin history advances only once the slave has taken the request.
         if ((state_reg == ST_REQ) && mem_gnt) begin
            last_owner_reg <= owner_reg;
         end
      end
   end

   mem_arb_timeout #(
      .LIMIT (8'(TIMEOUT))
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (timer_clear),
      .enable  (timer_en),
      .expired (timer_expired)
   );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: hand-computed vectors, slave responses
// driven cycle by cycle, shortened timeout.
module tb_mem_arbiter;

   localparam int unsigned TO  = 8;
   localparam logic [31:0] ERR = 32'hDEADBEEF;

   logic        clk;
   logic        rst;
   logic        ifu_req;
   logic [31:0] ifu_addr;
   logic        ifu_ready, ifu_rvalid, ifu_err;
   logic [31:0] ifu_rdata;
   logic        lsu_req, lsu_wen;
   logic [31:0] lsu_addr, lsu_wdata;
   logic [3:0]  lsu_wstrb;
   logic        lsu_ready, lsu_rvalid, lsu_err;
   logic [31:0] lsu_rdata;
   logic        mem_req, mem_wen;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;

   int checks   = 0;
   int failures = 0;

   mem_arbiter #(
      .TIMEOUT   (TO),
      .ERR_RDATA (ERR)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ifu_req    (ifu_req),
      .ifu_addr   (ifu_addr),
      .ifu_ready  (ifu_ready),
      .ifu_rvalid (ifu_rvalid),
      .ifu_rdata  (ifu_rdata),
      .ifu_err    (ifu_err),
      .lsu_req    (lsu_req),
      .lsu_wen    (lsu_wen),
      .lsu_addr   (lsu_addr),
      .lsu_wdata  (lsu_wdata),
      .lsu_wstrb  (lsu_wstrb),
      .lsu_ready  (lsu_ready),
      .lsu_rvalid (lsu_rvalid),
      .lsu_rdata  (lsu_rdata),
      .lsu_err    (lsu_err),
      .mem_req    (mem_req),
      .mem_wen    (mem_wen),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wstrb  (mem_wstrb),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("ok   %s = %h", tag, got);
      end
   endtask

   // Inputs change 1 unit after posedge; outputs are sampled 3 units later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   initial begin
      logic exp_lsu [3];
      exp_lsu = '{1'b1, 1'b0, 1'b1};

      rst = 1'b0;
      ifu_req = 1'b0; ifu_addr = 32'd0;
      lsu_req = 1'b0; lsu_wen = 1'b0; lsu_addr = 32'd0; lsu_wdata = 32'd0; lsu_wstrb = 4'd0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
      step(); step();
      settle();
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_ifu_ready", ifu_ready, 1'b0);
      check("rst_lsu_rvalid", lsu_rvalid, 1'b0);
      step();
      rst = 1'b1;
      step();

      // IFU only, immediate grant, response one cycle later
      ifu_req = 1'b1; ifu_addr = 32'h8000_0000;
      settle();
      check("t2_ifu_ready", ifu_ready, 1'b1);
      check("t2_lsu_ready", lsu_ready, 1'b0);
      check("t2_mem_req_T", mem_req, 1'b0);
      step();
      ifu_req = 1'b0; ifu_addr = 32'd0; mem_gnt = 1'b1;
      settle();
      check("t2_mem_req_T1", mem_req, 1'b1);
      check("t2_mem_addr", mem_addr, 32'h8000_0000);
      check("t2_mem_wen", mem_wen, 1'b0);
      check("t2_rvalid_T1", ifu_rvalid, 1'b0);
      step();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0010_0073;
      settle();
      check("t2_ifu_rvalid_T2", ifu_rvalid, 1'b1);
      check("t2_ifu_rdata", ifu_rdata, 32'h0010_0073);
      check("t2_ifu_err", ifu_err, 1'b0);
      check("t2_lsu_rvalid", lsu_rvalid, 1'b0);
      check("t2_mem_req_resp", mem_req, 1'b0);
      step();
      mem_rvalid = 1'b0; mem_rdata = 32'd0;
      settle();
      check("t2_rvalid_pulse", ifu_rvalid, 1'b0);
      step();

      // Both request continuously: LSU, IFU, LSU
      ifu_req = 1'b1; ifu_addr = 32'h0000_1000;
      lsu_req = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h0000_2000; lsu_wstrb = 4'd0;
      for (int i = 0; i < 3; i++) begin
         settle();
         check($sformatf("rr%0d_lsu_ready", i), lsu_ready, exp_lsu[i]);
         check($sformatf("rr%0d_ifu_ready", i), ifu_ready, !exp_lsu[i]);
         step();
         mem_gnt = 1'b1;
         settle();
         check($sformatf("rr%0d_mem_addr", i), mem_addr, exp_lsu[i] ? 32'h0000_2000 : 32'h0000_1000);
         check($sformatf("rr%0d_no_ready_req", i), {ifu_ready, lsu_ready}, 2'b00);
         step();
         mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA0 + i;
         settle();
         check($sformatf("rr%0d_lsu_rvalid", i), lsu_rvalid, exp_lsu[i]);
         check($sformatf("rr%0d_ifu_rvalid", i), ifu_rvalid, !exp_lsu[i]);
         step();
         mem_rvalid = 1'b0;
      end
      ifu_req = 1'b0; lsu_req = 1'b0;
      step();

      // LSU store, grant delayed three cycles, payload must stay latched
      lsu_req = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_1004;
      lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'b1111;
      settle();
      check("t4_lsu_ready", lsu_ready, 1'b1);
      step();
      lsu_req = 1'b0; lsu_wen = 1'b0; lsu_addr = 32'd0; lsu_wdata = 32'd0; lsu_wstrb = 4'd0;
      for (int c = 0; c < 4; c++) begin
         mem_gnt = (c == 3);
         settle();
         check($sformatf("t4_c%0d_mem_req", c), mem_req, 1'b1);
         check($sformatf("t4_c%0d_mem_addr", c), mem_addr, 32'h8000_1004);
         check($sformatf("t4_c%0d_mem_wdata", c), mem_wdata, 32'h1234_5678);
         check($sformatf("t4_c%0d_mem_wstrb", c), mem_wstrb, 4'b1111);
         check($sformatf("t4_c%0d_mem_wen", c), mem_wen, 1'b1);
         step();
      end
      mem_gnt = 1'b0;
      settle();
      check("t4_wait_rvalid", lsu_rvalid, 1'b0);
      step();
      mem_rvalid = 1'b1; mem_rdata = 32'h0;
      settle();
      check("t4_ack_rvalid", lsu_rvalid, 1'b1);
      check("t4_ack_err", lsu_err, 1'b0);
      step();
      mem_rvalid = 1'b0;
      settle();
      check("t4_single_ack", lsu_rvalid, 1'b0);
      step();

      // LSU load with a mute slave: timeout error, late response swallowed
      lsu_req = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_2003; lsu_wstrb = 4'b0010;
      settle();
      check("t5_lsu_ready", lsu_ready, 1'b1);
      step();
      lsu_req = 1'b0; mem_gnt = 1'b1;
      settle();
      check("t5_load_wstrb", mem_wstrb, 4'b0000);
      check("t5_load_wen", mem_wen, 1'b0);
      step();
      mem_gnt = 1'b0;
      for (int c = 0; c < TO; c++) begin
         settle();
         check($sformatf("t5_silent%0d", c), lsu_rvalid, 1'b0);
         step();
      end
      settle();
      check("t5_err_rvalid", lsu_rvalid, 1'b1);
      check("t5_err_flag", lsu_err, 1'b1);
      check("t5_err_rdata", lsu_rdata, ERR);
      check("t5_err_ifu", ifu_rvalid, 1'b0);
      step();
      ifu_req = 1'b1; ifu_addr = 32'h8000_0010;
      settle();
      check("t5_flush_ready", ifu_ready, 1'b0);
      check("t5_flush_mem_req", mem_req, 1'b0);
      check("t5_flush_err", lsu_rvalid, 1'b0);
      step();
      mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
      settle();
      check("t5_stale_lsu", lsu_rvalid, 1'b0);
      check("t5_stale_ifu", ifu_rvalid, 1'b0);
      check("t5_stale_ready", ifu_ready, 1'b0);
      step();
      mem_rvalid = 1'b0;
      settle();
      check("t5_idle_ready", ifu_ready, 1'b1);
      step();
      ifu_req = 1'b0; mem_gnt = 1'b1;
      settle();
      check("t5_next_addr", mem_addr, 32'h8000_0010);
      step();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
      settle();
      check("t5_next_rdata", ifu_rdata, 32'h0000_0013);
      step();
      mem_rvalid = 1'b0;

      // IFU request withdrawn before ready, byte store strobes pass through
      lsu_req = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_3002;
      lsu_wdata = 32'h00AB_0000; lsu_wstrb = 4'b0100;
      settle();
      check("t6_lsu_ready", lsu_ready, 1'b1);
      step();
      lsu_req = 1'b0; ifu_req = 1'b1; ifu_addr = 32'h0000_4000;
      settle();
      check("t6_ifu_ready_busy", ifu_ready, 1'b0);
      check("t6_sb_wstrb", mem_wstrb, 4'b0100);
      check("t6_sb_wdata", mem_wdata, 32'h00AB_0000);
      step();
      ifu_req = 1'b0; mem_gnt = 1'b1;
      settle();
      check("t6_ifu_ready_drop", ifu_ready, 1'b0);
      step();
      mem_gnt = 1'b0; mem_rvalid = 1'b1;
      settle();
      check("t6_sb_ack", lsu_rvalid, 1'b1);
      step();
      mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
      settle();
      check("t6_idle_mem_req", mem_req, 1'b0);
      check("t6_idle_rvalid_ignored", {ifu_rvalid, lsu_rvalid}, 2'b00);
      step();
      mem_rvalid = 1'b0;
      settle();
      check("t6_idle_mem_req2", mem_req, 1'b0);
      step();

      // Reset asserted mid-RESP drops the transaction
      ifu_req = 1'b1; ifu_addr = 32'h8000_0100;
      step();
      ifu_req = 1'b0; mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      settle();
      check("t1_in_resp", mem_req, 1'b0);
      rst = 1'b0; ifu_req = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
      #1;
      check("t1_rst_ifu_rvalid", ifu_rvalid, 1'b0);
      check("t1_rst_ifu_ready", ifu_ready, 1'b0);
      check("t1_rst_ifu_rdata", ifu_rdata, 32'd0);
      check("t1_rst_mem_req", mem_req, 1'b0);
      step();
      mem_rvalid = 1'b0;
      rst = 1'b1;
      settle();
      check("t1_accept_after_rst", ifu_ready, 1'b1);
      step();
      ifu_req = 1'b0;
      settle();
      check("t1_mem_req_after_rst", mem_req, 1'b1);
      check("t1_mem_addr_after_rst", mem_addr, 32'h8000_0100);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
